// File: rtl/sample_and_hold_multi.sv
// sample_and_hold_multi
//   Multi-channel level stretcher. Each channel watches for ACTIVE_LEVEL on its input and holds
//   that level on its output for a run-time-selectable number of extra cycles, so that short
//   glitches from line-status/error detectors are seen by slower status/LED/USB consumers.
//
// Parameters
//   CHANNELS      number of independent channels
//   HOLD_MAX      largest hold length; hold_len_i above it is clamped
//   ACTIVE_LEVEL  level detected and held (0: zero-hold, 1: one-hold)
//   RETRIGGER     1: active input during a hold reloads the counter; 0: input ignored in hold
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous reset, active-low
//   signal_i    per-channel input lines, synchronous to clk_i
//   hold_len_i  hold length in cycles, sampled whenever a counter loads
//   flush_i     synchronous abort of all holds
//   clear_i     clears sticky_o                       (SAH_MULTI_STICKY_EN only)
//   sticky_o    per-channel "hold started" flags      (SAH_MULTI_STICKY_EN only)
//   signal_o    registered stretched outputs
//   busy_o      1 while the channel counter is non-zero
//
// Configuration
//   Define SAH_MULTI_STICKY_EN to add the sticky_o/clear_i ports and sticky flag registers.

module sample_and_hold_multi #(
    parameter int unsigned CHANNELS     = 8,
    parameter int unsigned HOLD_MAX     = 255,
    parameter bit          ACTIVE_LEVEL = 1'b0,
    parameter bit          RETRIGGER    = 1'b0,
    localparam int unsigned BITS        = $clog2(HOLD_MAX + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] signal_i,
    input  logic [BITS-1:0]     hold_len_i,
    input  logic                flush_i,
`ifdef SAH_MULTI_STICKY_EN
    input  logic                clear_i,
    output logic [CHANNELS-1:0] sticky_o,
`endif
    output logic [CHANNELS-1:0] signal_o,
    output logic [CHANNELS-1:0] busy_o
);

    logic [BITS-1:0]     len;
    logic [CHANNELS-1:0] active;
    logic [BITS-1:0]     cnt_q [CHANNELS];
    logic [BITS-1:0]     cnt_d [CHANNELS];
    logic [CHANNELS-1:0] sig_q, sig_d;
`ifdef SAH_MULTI_STICKY_EN
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] sticky_q, sticky_d;
`endif

    // Clamp keeps every loaded count <= HOLD_MAX, so the counter can never wrap.
    always_comb begin
        len = (hold_len_i > BITS'(HOLD_MAX)) ? BITS'(HOLD_MAX) : hold_len_i;
    end

    always_comb begin
        active = ACTIVE_LEVEL ? signal_i : ~signal_i;
    end

    // Per channel: cnt == 0 is IDLE (follow input), cnt > 0 is HOLD (drive ACTIVE_LEVEL).
    always_comb begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            cnt_d[n] = cnt_q[n];
            sig_d[n] = signal_i[n];
`ifdef SAH_MULTI_STICKY_EN
            load[n]  = 1'b0;
`endif
            if (flush_i) begin
                // Flush wins over any load or retrigger in the same cycle.
                cnt_d[n] = '0;
            end else if (cnt_q[n] == '0) begin
                if (active[n] && (len != '0)) begin
                    cnt_d[n] = len;
`ifdef SAH_MULTI_STICKY_EN
                    load[n]  = 1'b1;
`endif
                end
            end else begin
                sig_d[n] = ACTIVE_LEVEL;
                if (RETRIGGER && active[n]) begin
                    // A zero length here ends the hold: channel is IDLE next cycle.
                    cnt_d[n] = len;
                end else begin
                    cnt_d[n] = cnt_q[n] - BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= '0;
            end
            sig_q <= {CHANNELS{~ACTIVE_LEVEL}};
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            sig_q <= sig_d;
        end
    end

`ifdef SAH_MULTI_STICKY_EN
    // Only IDLE->HOLD loads set the flag; a set beats a simultaneous clear.
    always_comb begin
        sticky_d = (sticky_q & ~{CHANNELS{clear_i}}) | load;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_o = sticky_q;
`endif

    always_comb begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            busy_o[n] = (cnt_q[n] != '0);
        end
    end

    assign signal_o = sig_q;

endmodule

// File: tb/tb_sample_and_hold_multi.sv
// tb_sample_and_hold_multi
//   Self-checking bench for sample_and_hold_multi. Three instances run in lock-step:
//     u_dut : 8 channels, HOLD_MAX=255, zero-hold, no retrigger
//     u_rt  : same but RETRIGGER=1 (shares all inputs with u_dut)
//     u_b   : 2 channels, HOLD_MAX=5, one-hold, no retrigger
//   Expected outputs are pushed to a scoreboard queue as each cycle's stimulus is driven and
//   popped/compared after the clock edge. Sticky checks are built when SAH_MULTI_STICKY_EN is set.

module tb_sample_and_hold_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] sig_a, len_a;
    logic       flush_a;
    logic [7:0] so_a, bo_a, so_r, bo_r;
    logic [1:0] sig_b, so_b, bo_b;
    logic [2:0] len_b;
`ifdef SAH_MULTI_STICKY_EN
    logic       clear_a;
    logic [7:0] st_a, st_r;
    logic       clear_b;
    logic [1:0] st_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [7:0] sa, ba, sr, br;
        logic [1:0] sb, bb;
    } exp_t;

    exp_t sb_q[$];

    sample_and_hold_multi #(
        .CHANNELS(8), .HOLD_MAX(255), .ACTIVE_LEVEL(1'b0), .RETRIGGER(1'b0)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .signal_i(sig_a), .hold_len_i(len_a), .flush_i(flush_a),
`ifdef SAH_MULTI_STICKY_EN
        .clear_i(clear_a), .sticky_o(st_a),
`endif
        .signal_o(so_a), .busy_o(bo_a)
    );

    sample_and_hold_multi #(
        .CHANNELS(8), .HOLD_MAX(255), .ACTIVE_LEVEL(1'b0), .RETRIGGER(1'b1)
    ) u_rt (
        .clk_i(clk), .rst_ni(rst_n), .signal_i(sig_a), .hold_len_i(len_a), .flush_i(flush_a),
`ifdef SAH_MULTI_STICKY_EN
        .clear_i(clear_a), .sticky_o(st_r),
`endif
        .signal_o(so_r), .busy_o(bo_r)
    );

    sample_and_hold_multi #(
        .CHANNELS(2), .HOLD_MAX(5), .ACTIVE_LEVEL(1'b1), .RETRIGGER(1'b0)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .signal_i(sig_b), .hold_len_i(len_b), .flush_i(flush_a),
`ifdef SAH_MULTI_STICKY_EN
        .clear_i(clear_b), .sticky_o(st_b),
`endif
        .signal_o(so_b), .busy_o(bo_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected registered outputs, compare after edge.
    task automatic cyc(input string tag, input logic [7:0] s_a, input logic [7:0] l_a,
                       input logic f, input logic [1:0] s_b, input logic [2:0] l_b,
                       input logic [7:0] e_sa, input logic [7:0] e_ba,
                       input logic [7:0] e_sr, input logic [7:0] e_br,
                       input logic [1:0] e_sb, input logic [1:0] e_bb);
        exp_t e;
        sig_a   = s_a;
        len_a   = l_a;
        flush_a = f;
        sig_b   = s_b;
        len_b   = l_b;
        e.tag = tag;
        e.sa = e_sa; e.ba = e_ba; e.sr = e_sr; e.br = e_br; e.sb = e_sb; e.bb = e_bb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, ".sig"},    32'(so_a), 32'(e.sa));
        check_eq({e.tag, ".busy"},   32'(bo_a), 32'(e.ba));
        check_eq({e.tag, ".rt_sig"}, 32'(so_r), 32'(e.sr));
        check_eq({e.tag, ".rt_bsy"}, 32'(bo_r), 32'(e.br));
        check_eq({e.tag, ".b_sig"},  32'(so_b), 32'(e.sb));
        check_eq({e.tag, ".b_busy"}, 32'(bo_b), 32'(e.bb));
    endtask

    // u_dut and u_rt expected identical; u_b idle.
    task automatic cyc_a(input string tag, input logic [7:0] s_a, input logic [7:0] l_a,
                         input logic f, input logic [7:0] e_s, input logic [7:0] e_b);
        cyc(tag, s_a, l_a, f, 2'b00, 3'd0, e_s, e_b, e_s, e_b, 2'b00, 2'b00);
    endtask

    // u_dut and u_rt expected to differ; u_b idle.
    task automatic cyc_ar(input string tag, input logic [7:0] s_a, input logic [7:0] l_a,
                          input logic f, input logic [7:0] e_s, input logic [7:0] e_b,
                          input logic [7:0] e_sr, input logic [7:0] e_br);
        cyc(tag, s_a, l_a, f, 2'b00, 3'd0, e_s, e_b, e_sr, e_br, 2'b00, 2'b00);
    endtask

    // Exercise u_b; 8-channel instances idle.
    task automatic cyc_b(input string tag, input logic [1:0] s_b, input logic [2:0] l_b,
                         input logic [1:0] e_s, input logic [1:0] e_b);
        cyc(tag, 8'hFF, 8'd0, 1'b0, s_b, l_b, 8'hFF, 8'h00, 8'hFF, 8'h00, e_s, e_b);
    endtask

    initial begin
        rst_n   = 1'b0;
        sig_a   = 8'h00;
        len_a   = 8'd0;
        flush_a = 1'b0;
        sig_b   = 2'b00;
        len_b   = 3'd0;
`ifdef SAH_MULTI_STICKY_EN
        clear_a = 1'b0;
        clear_b = 1'b0;
`endif
        #12;
        check_eq("rst.sig",    32'(so_a), 32'h0FF);
        check_eq("rst.busy",   32'(bo_a), 32'h000);
        check_eq("rst.rt_sig", 32'(so_r), 32'h0FF);
        check_eq("rst.b_sig",  32'(so_b), 32'h000);
        check_eq("rst.b_busy", 32'(bo_b), 32'h000);
        sig_a = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a("rel0", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00);
        cyc_a("rel1", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00);

        // Basic hold, len 3, one-cycle zero on ch2.
        cyc_a("hold0", 8'hFB, 8'd3, 1'b0, 8'hFB, 8'h04);
        cyc_a("hold1", 8'hFF, 8'd3, 1'b0, 8'hFB, 8'h04);
        cyc_a("hold2", 8'hFF, 8'd3, 1'b0, 8'hFB, 8'h04);
        cyc_a("hold3", 8'hFF, 8'd3, 1'b0, 8'hFB, 8'h00);
        cyc_a("hold4", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00);

        // hold_len_i change mid-hold does not extend the running count.
        cyc_a("len0", 8'hFB, 8'd2, 1'b0, 8'hFB, 8'h04);
        cyc_a("len1", 8'hFF, 8'd9, 1'b0, 8'hFB, 8'h04);
        cyc_a("len2", 8'hFF, 8'd9, 1'b0, 8'hFB, 8'h00);
        cyc_a("len3", 8'hFF, 8'd9, 1'b0, 8'hFF, 8'h00);

        // Zeros on ch0 two cycles apart: ignored without retrigger, reload with it.
        cyc_ar("rt0", 8'hFE, 8'd3, 1'b0, 8'hFE, 8'h01, 8'hFE, 8'h01);
        cyc_ar("rt1", 8'hFF, 8'd3, 1'b0, 8'hFE, 8'h01, 8'hFE, 8'h01);
        cyc_ar("rt2", 8'hFE, 8'd3, 1'b0, 8'hFE, 8'h01, 8'hFE, 8'h01);
        cyc_ar("rt3", 8'hFF, 8'd3, 1'b0, 8'hFE, 8'h00, 8'hFE, 8'h01);
        cyc_ar("rt4", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00, 8'hFE, 8'h01);
        cyc_ar("rt5", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00, 8'hFE, 8'h00);
        cyc_ar("rt6", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00);

        // Retrigger with len 0 ends the hold early.
        cyc_ar("rz0", 8'hFD, 8'd3, 1'b0, 8'hFD, 8'h02, 8'hFD, 8'h02);
        cyc_ar("rz1", 8'hFD, 8'd0, 1'b0, 8'hFD, 8'h02, 8'hFD, 8'h00);
        cyc_ar("rz2", 8'hFF, 8'd0, 1'b0, 8'hFD, 8'h02, 8'hFF, 8'h00);
        cyc_ar("rz3", 8'hFF, 8'd0, 1'b0, 8'hFD, 8'h00, 8'hFF, 8'h00);
        cyc_ar("rz4", 8'hFF, 8'd0, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00);

        // len 0: pure registered pass-through.
        cyc_a("pt0", 8'hF0, 8'd0, 1'b0, 8'hF0, 8'h00);
        cyc_a("pt1", 8'h0F, 8'd0, 1'b0, 8'h0F, 8'h00);
        cyc_a("pt2", 8'hFF, 8'd0, 1'b0, 8'hFF, 8'h00);

        // Independent overlapping holds on ch3 and ch5.
        cyc_a("mc0", 8'hF7, 8'd2, 1'b0, 8'hF7, 8'h08);
        cyc_a("mc1", 8'hDF, 8'd2, 1'b0, 8'hD7, 8'h28);
        cyc_a("mc2", 8'hFF, 8'd2, 1'b0, 8'hD7, 8'h20);
        cyc_a("mc3", 8'hFF, 8'd2, 1'b0, 8'hDF, 8'h00);
        cyc_a("mc4", 8'hFF, 8'd2, 1'b0, 8'hFF, 8'h00);

        // Flush during ch0 hold while ch1 sees a zero: both idle, no new load.
        cyc_a("fl0", 8'hFE, 8'd3, 1'b0, 8'hFE, 8'h01);
        cyc_a("fl1", 8'hFD, 8'd3, 1'b1, 8'hFD, 8'h00);
        cyc_a("fl2", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00);

        // HOLD_MAX=5, hold_len 7 clamps to 5 -> 6 cycles high.
        cyc_b("cl0", 2'b01, 3'd7, 2'b01, 2'b01);
        cyc_b("cl1", 2'b00, 3'd7, 2'b01, 2'b01);
        cyc_b("cl2", 2'b00, 3'd7, 2'b01, 2'b01);
        cyc_b("cl3", 2'b00, 3'd7, 2'b01, 2'b01);
        cyc_b("cl4", 2'b00, 3'd7, 2'b01, 2'b01);
        cyc_b("cl5", 2'b00, 3'd7, 2'b01, 2'b00);
        cyc_b("cl6", 2'b00, 3'd7, 2'b00, 2'b00);
        cyc_b("b2_0", 2'b10, 3'd2, 2'b10, 2'b10);
        cyc_b("b2_1", 2'b00, 3'd2, 2'b10, 2'b10);
        cyc_b("b2_2", 2'b00, 3'd2, 2'b10, 2'b00);
        cyc_b("b2_3", 2'b00, 3'd2, 2'b00, 2'b00);
        cyc_b("bp0", 2'b10, 3'd0, 2'b10, 2'b00);
        cyc_b("bp1", 2'b01, 3'd0, 2'b01, 2'b00);
        cyc_b("bp2", 2'b00, 3'd0, 2'b00, 2'b00);

        // Reset mid-hold acts asynchronously.
        cyc_a("rmh0", 8'hFB, 8'd3, 1'b0, 8'hFB, 8'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rmh.sig",    32'(so_a), 32'h0FF);
        check_eq("rmh.busy",   32'(bo_a), 32'h000);
        check_eq("rmh.rt_bsy", 32'(bo_r), 32'h000);
`ifdef SAH_MULTI_STICKY_EN
        check_eq("rmh.sticky", 32'(st_a), 32'h000);
`endif
        sig_a = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a("rmh1", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00);

`ifdef SAH_MULTI_STICKY_EN
        clear_a = 1'b0;
        cyc_a("sk_load", 8'hFB, 8'd3, 1'b0, 8'hFB, 8'h04);
        check_eq("sk_load.st", 32'(st_a), 32'h04);
        clear_a = 1'b1;
        cyc_a("sk_setclr", 8'hF7, 8'd3, 1'b0, 8'hF3, 8'h0C);
        check_eq("sk_setclr.st", 32'(st_a), 32'h08);
        clear_a = 1'b0;
        cyc_a("sk_flush", 8'hFF, 8'd3, 1'b1, 8'hFF, 8'h00);
        check_eq("sk_flush.st", 32'(st_a), 32'h08);
        clear_a = 1'b1;
        cyc_a("sk_clr", 8'hFF, 8'd3, 1'b0, 8'hFF, 8'h00);
        check_eq("sk_clr.st", 32'(st_a), 32'h00);
        clear_a = 1'b0;
        cyc_a("sk_rt0", 8'hFE, 8'd3, 1'b0, 8'hFE, 8'h01);
        check_eq("sk_rt0.st", 32'(st_r), 32'h01);
        clear_a = 1'b1;
        cyc_a("sk_rt1", 8'hFF, 8'd3, 1'b0, 8'hFE, 8'h01);
        check_eq("sk_rt1.st", 32'(st_r), 32'h00);
        clear_a = 1'b0;
        cyc_ar("sk_rt2", 8'hFE, 8'd3, 1'b0, 8'hFE, 8'h01, 8'hFE, 8'h01);
        check_eq("sk_rt2.st", 32'(st_r), 32'h00);
        check_eq("sk_rt2.st_a", 32'(st_a), 32'h00);
        cyc_a("sk_end", 8'hFF, 8'd3, 1'b1, 8'hFF, 8'h00);
        check_eq("sk_end.st_b", 32'(st_b), 32'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
